// File: rtl/nv_nvdla_dma_wr_pkt_pkg.sv
// nv_nvdla_dma_pkg: shared DMA write packet widths, field offsets, packet ids, FSM states and packers
package nv_nvdla_dma_pkg;
  localparam int DMA_WR_PD_W = 515;
  localparam int DMA_WR_CMD_W = 78;
  localparam int DMA_WR_DAT_W = 514;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W = 64;
  localparam int SIZE_LSB = 64;
  localparam int SIZE_W = 13;
  localparam int ACK_BIT = 77;
  localparam int DATA_W = 512;
  localparam int MASK_LSB = 512;
  localparam int MASK_W = 2;
  localparam int PKT_ID_BIT = 514;
  localparam logic PKT_CMD = 1'b0;
  localparam logic PKT_DAT = 1'b1;
  typedef enum logic {IDLE, DAT} dma_wr_state_e;
  function automatic logic [DMA_WR_PD_W-1:0] cmd_pkt(logic [ADDR_W-1:0] addr, logic [SIZE_W-1:0] size, logic ack);
    logic [DMA_WR_PD_W-1:0] p;
    p = '0;
    p[ADDR_LSB +: ADDR_W] = addr;
    p[SIZE_LSB +: SIZE_W] = size;
    p[ACK_BIT] = ack;
    p[PKT_ID_BIT] = PKT_CMD;
    return p;
  endfunction
  function automatic logic [DMA_WR_PD_W-1:0] dat_pkt(logic [DATA_W-1:0] data, logic [MASK_W-1:0] mask);
    logic [DMA_WR_PD_W-1:0] p;
    p = '0;
    p[DATA_W-1:0] = data;
    p[MASK_LSB +: MASK_W] = mask;
    p[PKT_ID_BIT] = PKT_DAT;
    return p;
  endfunction
endpackage

// File: rtl/nv_nvdla_dma_wr_pkt_if.sv
// nv_nvdla_dma_wr_pkt_if: cmd, data and wr_req handshake bundle of the DMA write packetizer
interface nv_nvdla_dma_wr_pkt_if;
  import nv_nvdla_dma_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [SIZE_W-1:0] cmd_size;
  logic cmd_require_ack;
  logic dat_valid;
  logic dat_ready;
  logic [DATA_W-1:0] dat_data;
  logic wr_req_valid;
  logic wr_req_ready;
  logic [DMA_WR_PD_W-1:0] wr_req_pd;
  modport master (
    output cmd_valid, cmd_addr, cmd_size, cmd_require_ack, dat_valid, dat_data, wr_req_ready,
    input cmd_ready, dat_ready, wr_req_valid, wr_req_pd
  );
  modport slave (
    input cmd_valid, cmd_addr, cmd_size, cmd_require_ack, dat_valid, dat_data, wr_req_ready,
    output cmd_ready, dat_ready, wr_req_valid, wr_req_pd
  );
endinterface

// File: rtl/nv_nvdla_dma_wr_pkt_ack_cnt.sv
// nv_nvdla_dma_ack_cnt: outstanding acked-write up/down counter with limit flag
module nv_nvdla_dma_ack_cnt #(
  parameter int MAX = 255
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  input  logic inc,
  input  logic dec,
  output logic [7:0] cnt,
  output logic full
);
  assign full = cnt == 8'(MAX);
  always_ff @(posedge nvdla_core_clk)
    if (!nvdla_core_rstn) cnt <= '0;
    else if (inc && !dec) cnt <= cnt + 8'd1;
    else if (dec && !inc && cnt != '0) cnt <= cnt - 8'd1;
  assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn) !(dec && !inc && cnt == '0));
endmodule

// File: rtl/nv_nvdla_dma_wr_pkt.sv
// nv_nvdla_dma_wr_pkt: cmd/data to wr_req packetizer with ack tracking; NVDLA_DMA_WR_PERF_EN adds perf_stall_cnt
module nv_nvdla_dma_wr_pkt
  import nv_nvdla_dma_pkg::*;
#(
  parameter int MAX_OS_ACK = 255
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  nv_nvdla_dma_wr_pkt_if.slave io,
  input  logic wr_rsp_complete,
  output logic [7:0] os_ack_cnt,
  output logic dp2reg_idle
`ifdef NVDLA_DMA_WR_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);
  dma_wr_state_e state, state_nxt;
  logic [11:0] beat_cnt;
  logic last_half, load_en, ack_ok, ack_full, cmd_acc, dat_acc, last_beat, ack_inc;
  assign load_en = !io.wr_req_valid || io.wr_req_ready;
  assign ack_ok = !io.cmd_require_ack || !ack_full;
  assign io.cmd_ready = nvdla_core_rstn && state == IDLE && load_en && ack_ok;
  assign io.dat_ready = nvdla_core_rstn && state == DAT && load_en;
  assign cmd_acc = io.cmd_valid && io.cmd_ready;
  assign dat_acc = io.dat_valid && io.dat_ready;
  assign last_beat = beat_cnt == '0;
  assign ack_inc = io.wr_req_valid && io.wr_req_ready && io.wr_req_pd[PKT_ID_BIT] == PKT_CMD && io.wr_req_pd[ACK_BIT];
  assign dp2reg_idle = state == IDLE && !io.wr_req_valid && os_ack_cnt == '0;
  always_comb begin
    state_nxt = cmd_acc ? DAT : (dat_acc && last_beat) ? IDLE : state;
  end
  always_ff @(posedge nvdla_core_clk)
    if (!nvdla_core_rstn) begin
      state <= IDLE;
      beat_cnt <= '0;
      last_half <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_acc) begin
        beat_cnt <= io.cmd_size[SIZE_W-1:1];
        last_half <= !io.cmd_size[0];
      end else if (dat_acc && !last_beat) beat_cnt <= beat_cnt - 12'd1;
    end
  always_ff @(posedge nvdla_core_clk)
    if (!nvdla_core_rstn) begin
      io.wr_req_valid <= 1'b0;
      io.wr_req_pd <= '0;
    end else if (load_en) begin
      io.wr_req_valid <= cmd_acc || dat_acc;
      if (cmd_acc) io.wr_req_pd <= cmd_pkt(io.cmd_addr, io.cmd_size, io.cmd_require_ack);
      else if (dat_acc) io.wr_req_pd <= dat_pkt(io.dat_data, (last_beat && last_half) ? 2'b01 : 2'b11);
    end
  nv_nvdla_dma_ack_cnt #(.MAX(MAX_OS_ACK)) u_ack_cnt (
    .nvdla_core_clk(nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .inc(ack_inc),
    .dec(wr_rsp_complete),
    .cnt(os_ack_cnt),
    .full(ack_full)
  );
`ifdef NVDLA_DMA_WR_PERF_EN
  always_ff @(posedge nvdla_core_clk)
    if (!nvdla_core_rstn) perf_stall_cnt <= '0;
    else if (io.wr_req_valid && !io.wr_req_ready && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_nv_nvdla_dma_wr_pkt.sv
// tb_nv_nvdla_dma_wr_pkt: table, directed and random checks of the DMA write packetizer against a packet-queue model
module tb_nv_nvdla_dma_wr_pkt;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic cpl = 1'b0;
  logic [7:0] os_ack_cnt;
  logic idle;
`ifdef NVDLA_DMA_WR_PERF_EN
  logic [31:0] perf;
`endif
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [514:0] exp_q[$];
  int m_os = 0;
  bit held = 0;
  logic [514:0] held_pd;
  int mon_dat_cnt = 0;
  int mon_cmd_cyc = 0;
  int mon_last_cyc = 0;
  logic [1:0] mon_last_mask = 2'b00;
  bit rand_rdy = 0;
  bit rand_cpl = 0;
  typedef struct packed {
    logic [63:0] addr;
    logic [12:0] size;
    int beats;
    logic [1:0] last_mask;
  } vec_t;
  vec_t vt[6];
  nv_nvdla_dma_wr_pkt_if bus();
  nv_nvdla_dma_wr_pkt dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rstn(rstn),
    .io(bus),
    .wr_rsp_complete(cpl),
    .os_ack_cnt(os_ack_cnt),
    .dp2reg_idle(idle)
`ifdef NVDLA_DMA_WR_PERF_EN
    ,
    .perf_stall_cnt(perf)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string name, logic [514:0] act, logic [514:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [514:0] m_cmd(logic [63:0] a, logic [12:0] s, logic k);
    logic [514:0] p;
    p = '0;
    p[63:0] = a;
    p[76:64] = s;
    p[77] = k;
    return p;
  endfunction
  function automatic logic [514:0] m_dat(logic [511:0] d, logic [1:0] m);
    logic [514:0] p;
    p = '0;
    p[511:0] = d;
    p[513:512] = m;
    p[514] = 1'b1;
    return p;
  endfunction
  function automatic logic [511:0] mkdat(int tag, int i);
    logic [31:0] w;
    w = 32'(tag) * 32'h9E37_79B9 + 32'(i) * 32'h0101_0101;
    return {16{w}};
  endfunction
  function automatic int n_beats(logic [12:0] s);
    return (int'(s) + 2) / 2;
  endfunction
  task automatic expect_cmd(logic [63:0] a, logic [12:0] s, logic k, int tag);
    int atoms;
    atoms = int'(s) + 1;
    exp_q.push_back(m_cmd(a, s, k));
    for (int i = 0; i < n_beats(s); i++)
      exp_q.push_back(m_dat(mkdat(tag, i), {(2 * i + 1 < atoms), 1'b1}));
  endtask
  task automatic wait_rdy(bit d);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d ? bus.dat_ready : bus.cmd_ready) && n < 5000);
    if (!(d ? bus.dat_ready : bus.cmd_ready)) begin
      $display("FAIL handshake_timeout: got ready=0 expected ready=1 (dat=%0d)", d);
      $fatal(1);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic put_cmd(logic [63:0] a, logic [12:0] s, logic k);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = a;
    bus.cmd_size = s;
    bus.cmd_require_ack = k;
    wait_rdy(1'b0);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic put_dat(int tag, int nb, bit gap);
    for (int i = 0; i < nb; i++) begin
      if (gap && $urandom_range(0, 2) == 0) begin
        bus.dat_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.dat_valid = 1'b1;
      bus.dat_data = mkdat(tag, i);
      wait_rdy(1'b1);
    end
    bus.dat_valid = 1'b0;
  endtask
  task automatic send(logic [63:0] a, logic [12:0] s, logic k, int tag, bit gap);
    expect_cmd(a, s, k, tag);
    put_cmd(a, s, k);
    put_dat(tag, n_beats(s), gap);
  endtask
  always @(negedge clk) begin
    logic [514:0] e;
    bit inc;
    if (!rstn) begin
      exp_q.delete();
      m_os = 0;
      held = 0;
    end else begin
      if (held) begin
        chk("hold_valid", bus.wr_req_valid, 1);
        chk("hold_pd", bus.wr_req_pd, held_pd);
      end
      held = bus.wr_req_valid && !bus.wr_req_ready;
      held_pd = bus.wr_req_pd;
      chk("os_ack_cnt", os_ack_cnt, m_os);
      inc = 0;
      if (bus.wr_req_valid && bus.wr_req_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL extra_pkt: got %0h expected no packet", bus.wr_req_pd);
        end else begin
          e = exp_q.pop_front();
          chk("pkt", bus.wr_req_pd, e);
          inc = !e[514] && e[77];
          if (!bus.wr_req_pd[514]) begin
            mon_dat_cnt = 0;
            mon_cmd_cyc = cyc;
          end else begin
            mon_dat_cnt++;
            mon_last_mask = bus.wr_req_pd[513:512];
            mon_last_cyc = cyc;
          end
        end
      end
      if (inc && !cpl) m_os++;
      else if (cpl && !inc && m_os > 0) m_os--;
    end
  end
  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) bus.wr_req_ready = $urandom_range(0, 3) != 0;
    if (rand_cpl) cpl = m_os > 0 && $urandom_range(0, 3) == 0;
  end
  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int acc;
    vt[0] = '{64'h1000, 13'd3, 2, 2'b11};
    vt[1] = '{64'h2000, 13'd4, 3, 2'b01};
    vt[2] = '{64'h0020, 13'd0, 1, 2'b01};
    vt[3] = '{64'h0040, 13'd1, 1, 2'b11};
    vt[4] = '{64'h3000, 13'd2, 2, 2'b01};
    vt[5] = '{64'hFFFF_FFFF_FFFF_FFE0, 13'd8191, 4096, 2'b11};
    bus.cmd_valid = 0;
    bus.cmd_addr = '0;
    bus.cmd_size = '0;
    bus.cmd_require_ack = 0;
    bus.dat_valid = 0;
    bus.dat_data = '0;
    bus.wr_req_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.wr_req_valid, 0);
    chk("rst_pd", bus.wr_req_pd, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_dat_ready", bus.dat_ready, 0);
    chk("rst_os", os_ack_cnt, 0);
    chk("rst_idle", idle, 1);
    @(posedge clk);
    #1 rstn = 1;
    for (int i = 0; i < 6; i++) begin
      expect_cmd(vt[i].addr, vt[i].size, 1'b0, i);
      put_cmd(vt[i].addr, vt[i].size, 1'b0);
      acc = cyc;
      put_dat(i, n_beats(vt[i].size), 1'b0);
      @(negedge clk);
      chk("fsm_idle_cmd_ready", bus.cmd_ready, 1);
      chk("fsm_idle_dat_ready", bus.dat_ready, 0);
      @(negedge clk);
      chk("tbl_beats", mon_dat_cnt, vt[i].beats);
      chk("tbl_last_mask", mon_last_mask, vt[i].last_mask);
      chk("tbl_latency", mon_cmd_cyc, acc);
      chk("tbl_back_to_back", mon_last_cyc - mon_cmd_cyc, vt[i].beats);
      @(posedge clk);
      #1;
    end
    fork
      send(64'h5000, 13'd7, 1'b0, 100, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 bus.wr_req_ready = 0;
        repeat (5) @(posedge clk);
        #1 bus.wr_req_ready = 1;
      end
    join
    repeat (2) @(negedge clk);
    chk("stall_drained", exp_q.size(), 0);
`ifdef NVDLA_DMA_WR_PERF_EN
    chk("perf_stall_cnt", perf, 5);
`endif
    @(posedge clk);
    #1;
    for (int i = 0; i < 255; i++) send(64'h10000 + 64'(i) * 32, 13'd0, 1'b1, 200 + i, 1'b0);
    repeat (2) @(negedge clk);
    chk("os_full", os_ack_cnt, 255);
    chk("idle_busy", idle, 0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1;
    bus.cmd_addr = 64'hA000;
    bus.cmd_size = 0;
    bus.cmd_require_ack = 1;
    repeat (3) begin
      @(negedge clk);
      chk("ack_blocked", bus.cmd_ready, 0);
    end
    @(posedge clk);
    #1 bus.cmd_valid = 0;
    send(64'h9000, 13'd1, 1'b0, 500, 1'b0);
    expect_cmd(64'hA000, 13'd0, 1'b1, 501);
    bus.cmd_valid = 1;
    bus.cmd_addr = 64'hA000;
    bus.cmd_size = 0;
    bus.cmd_require_ack = 1;
    @(negedge clk);
    chk("ack_blocked2", bus.cmd_ready, 0);
    @(posedge clk);
    #1 cpl = 1;
    @(posedge clk);
    #1 cpl = 0;
    put_cmd(64'hA000, 13'd0, 1'b1);
    put_dat(501, 1, 1'b0);
    repeat (2) @(negedge clk);
    chk("os_refull", os_ack_cnt, 255);
    @(posedge clk);
    #1 cpl = 1;
    repeat (248) @(posedge clk);
    #1 cpl = 0;
    @(negedge clk);
    chk("os_seven", os_ack_cnt, 7);
    @(posedge clk);
    #1;
    expect_cmd(64'hB000, 13'd2, 1'b1, 600);
    put_cmd(64'hB000, 13'd2, 1'b1);
    cpl = 1;
    @(posedge clk);
    #1 cpl = 0;
    @(negedge clk);
    chk("os_inc_dec_same", os_ack_cnt, 7);
    @(posedge clk);
    #1;
    put_dat(600, 2, 1'b0);
    cpl = 1;
    repeat (7) @(posedge clk);
    #1 cpl = 0;
    @(negedge clk);
    chk("os_zero", os_ack_cnt, 0);
    @(posedge clk);
    #1;
    expect_cmd(64'hC000, 13'd5, 1'b1, 700);
    put_cmd(64'hC000, 13'd5, 1'b1);
    put_dat(700, 1, 1'b0);
    bus.dat_valid = 1;
    bus.dat_data = mkdat(700, 1);
    rstn = 0;
    @(posedge clk);
    #1 bus.dat_valid = 0;
    @(negedge clk);
    chk("mid_rst_valid", bus.wr_req_valid, 0);
    chk("mid_rst_os", os_ack_cnt, 0);
    chk("mid_rst_idle", idle, 1);
    chk("mid_rst_cmd_ready", bus.cmd_ready, 0);
    @(posedge clk);
    #1 rstn = 1;
    send(64'hD000, 13'd4, 1'b1, 701, 1'b0);
    repeat (2) @(negedge clk);
    chk("post_rst_os", os_ack_cnt, 1);
    chk("post_rst_drained", exp_q.size(), 0);
    @(posedge clk);
    #1 cpl = 1;
    @(posedge clk);
    #1 cpl = 0;
    rand_rdy = 1;
    rand_cpl = 1;
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFE0, 13'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1000 + i, 1'b1);
    end
    @(posedge clk);
    rand_rdy = 0;
    rand_cpl = 0;
    #2;
    bus.wr_req_ready = 1;
    cpl = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 300 && m_os > 0; k++) begin
      cpl = 1;
      @(posedge clk);
      #1 cpl = 0;
    end
    repeat (3) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    chk("final_os", os_ack_cnt, 0);
    chk("final_idle", idle, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
